// File: rtl/rs_issue_pool_pkg.sv
// Shared defaults for the reservation-station issue pool and the position
// of the memory-request flag inside a uop.
package rs_issue_pool_pkg;
   localparam int DEF_NUM_RS   = 4;
   localparam int DEF_MAX_UOPS = 3;
   localparam int DEF_UOP_W    = 20;
   localparam int DEF_DATA_W   = 16;

   // The memory-request flag is always the uop MSB.
   localparam int MEM_FLAG_POS = DEF_UOP_W - 1;

   function automatic int mem_flag_pos(input int uop_w);
      return uop_w - 1;
   endfunction
endpackage

// File: rtl/rs_slot.sv
// One reservation station: shift-out uop FIFO with head at the LSBs,
// remaining-uop count and a temp register.
module rs_slot
   import rs_issue_pool_pkg::*;
#(
   parameter  int MAX_UOPS = DEF_MAX_UOPS,
   parameter  int UOP_W    = DEF_UOP_W,
   parameter  int DATA_W   = DEF_DATA_W,
   localparam int CNT_W    = $clog2(MAX_UOPS + 1)
) (
   input  logic                      clk,
   input  logic                      a_rst,
   input  logic                      load,
   input  logic [MAX_UOPS*UOP_W-1:0] load_uops,
   input  logic [CNT_W-1:0]          load_cnt,
   input  logic [DATA_W-1:0]         load_temp,
   input  logic                      pop,
   input  logic                      temp_wr,
   input  logic [DATA_W-1:0]         temp_wr_data,
   output logic [CNT_W-1:0]          count,
   output logic [UOP_W-1:0]          head,
   output logic [DATA_W-1:0]         temp
);
   logic [MAX_UOPS*UOP_W-1:0] uops_q, uops_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]         temp_q, temp_d;

   always_comb begin
      uops_d = uops_q;
      cnt_d  = cnt_q;
      temp_d = temp_q;
      if (load) begin
         uops_d = load_uops;
         cnt_d  = load_cnt;
      end else if (pop) begin
         uops_d = uops_q >> UOP_W;
         cnt_d  = cnt_q - CNT_W'(1);
      end
      // A new group's constant overrides a same-cycle memory response.
      if (load)
         temp_d = load_temp;
      else if (temp_wr)
         temp_d = temp_wr_data;
   end

   always_ff @(posedge clk) begin
      if (a_rst) begin
         uops_q <= '0;
         cnt_q  <= '0;
         temp_q <= '0;
      end else begin
         uops_q <= uops_d;
         cnt_q  <= cnt_d;
         temp_q <= temp_d;
      end
   end

   assign count = cnt_q;
   assign head  = uops_q[UOP_W-1:0];
   assign temp  = temp_q;
endmodule

// File: rtl/rs_issue_pool.sv
// Reservation-station pool: dispatches decoded uop groups into free stations
// and issues one uop per cycle round-robin, stalling memory uops while busy.
module rs_issue_pool
   import rs_issue_pool_pkg::*;
#(
   parameter  int NUM_RS   = DEF_NUM_RS,
   parameter  int MAX_UOPS = DEF_MAX_UOPS,
   parameter  int UOP_W    = DEF_UOP_W,
   parameter  int DATA_W   = DEF_DATA_W,
   localparam int CNT_W    = $clog2(MAX_UOPS + 1),
   localparam int TAG_W    = $clog2(NUM_RS)
) (
   input  logic                      clk,
   input  logic                      a_rst,
   input  logic                      hold,
   input  logic                      id_valid,
   output logic                      id_ready,
   input  logic [MAX_UOPS*UOP_W-1:0] id_uops,
   input  logic [CNT_W-1:0]          id_uop_cnt,
   input  logic [DATA_W-1:0]         id_k16,
   input  logic                      mem_data_wr,
   input  logic [TAG_W-1:0]          mem_data_tag,
   input  logic [DATA_W-1:0]         mem_data_in,
   output logic                      ex_valid,
   output logic [UOP_W-1:0]          ex_uop,
   output logic [TAG_W-1:0]          ex_rs_id,
   output logic [DATA_W-1:0]         ex_t16,
   output logic                      ex_last,
   output logic                      mem_busy
);
   localparam int                MEM_BIT = mem_flag_pos(UOP_W);
   localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_UOPS);
   localparam logic [CNT_W-1:0]  ONE_CNT = CNT_W'(1);
   localparam logic [TAG_W-1:0]  LAST_RS = TAG_W'(NUM_RS - 1);
   localparam logic [NUM_RS-1:0] ONE_RS  = NUM_RS'(1);

   logic [NUM_RS-1:0] empty, elig, is_last, load, pop, temp_wr;
   logic [CNT_W-1:0]  cnt  [NUM_RS];
   logic [UOP_W-1:0]  head [NUM_RS];
   logic [DATA_W-1:0] temp [NUM_RS];

   logic [NUM_RS-1:0] disp_oh, gnt_oh, elig_hi, rr_mask;
   logic              cnt_ok, disp_fire, issue, gnt_last;
   logic [TAG_W-1:0]  gnt_idx;
   logic [UOP_W-1:0]  gnt_uop;
   logic [DATA_W-1:0] gnt_temp;

   logic [TAG_W-1:0][NUM_RS-1:0]  idx_t;
   logic [UOP_W-1:0][NUM_RS-1:0]  uop_t;
   logic [DATA_W-1:0][NUM_RS-1:0] tmp_t;

   logic [TAG_W-1:0]  rr_q, rr_d;
   logic              mem_busy_q, mem_busy_d;
   logic              ex_valid_q, ex_valid_d;
   logic [UOP_W-1:0]  ex_uop_q, ex_uop_d;
   logic [TAG_W-1:0]  ex_rs_id_q, ex_rs_id_d;
   logic [DATA_W-1:0] ex_t16_q, ex_t16_d;
   logic              ex_last_q, ex_last_d;

   for (genvar g = 0; g < NUM_RS; g++) begin : g_rs
      rs_slot #(
         .MAX_UOPS (MAX_UOPS),
         .UOP_W    (UOP_W),
         .DATA_W   (DATA_W)
      ) u_slot (
         .clk          (clk),
         .a_rst        (a_rst),
         .load         (load[g]),
         .load_uops    (id_uops),
         .load_cnt     (id_uop_cnt),
         .load_temp    (id_k16),
         .pop          (pop[g]),
         .temp_wr      (temp_wr[g]),
         .temp_wr_data (mem_data_in),
         .count        (cnt[g]),
         .head         (head[g]),
         .temp         (temp[g])
      );

      assign empty[g]   = (cnt[g] == '0);
      assign is_last[g] = (cnt[g] == ONE_CNT);
      assign elig[g]    = !empty[g] && !(head[g][MEM_BIT] && mem_busy_q);
      assign temp_wr[g] = mem_data_wr && (mem_data_tag == TAG_W'(g));

      // One-hot grant muxes, built bit-sliced so no variable indexing is needed.
      for (genvar b = 0; b < TAG_W; b++) begin : g_idx
         assign idx_t[b][g] = gnt_oh[g] && (((g >> b) & 1) != 0);
      end
      for (genvar b = 0; b < UOP_W; b++) begin : g_uop
         assign uop_t[b][g] = gnt_oh[g] & head[g][b];
      end
      for (genvar b = 0; b < DATA_W; b++) begin : g_tmp
         assign tmp_t[b][g] = gnt_oh[g] & temp[g][b];
      end
   end

   for (genvar b = 0; b < TAG_W; b++) begin : g_idx_or
      assign gnt_idx[b] = |idx_t[b];
   end
   for (genvar b = 0; b < UOP_W; b++) begin : g_uop_or
      assign gnt_uop[b] = |uop_t[b];
   end
   for (genvar b = 0; b < DATA_W; b++) begin : g_tmp_or
      assign gnt_temp[b] = |tmp_t[b];
   end

   assign id_ready = |empty;
   assign gnt_last = |(gnt_oh & is_last);

   always_comb begin
      cnt_ok    = (id_uop_cnt != '0) && (id_uop_cnt <= MAX_CNT);
      disp_fire = id_valid && id_ready && cnt_ok;
      disp_oh   = empty & (~empty + ONE_RS);
      load      = disp_fire ? disp_oh : '0;
      // rr_q is the first index searched; wrap to the low half if nothing above it.
      rr_mask   = ~((ONE_RS << rr_q) - ONE_RS);
      elig_hi   = elig & rr_mask;
      gnt_oh    = (elig_hi != '0) ? (elig_hi & (~elig_hi + ONE_RS))
                                  : (elig & (~elig + ONE_RS));
      issue     = !hold && (elig != '0);
      pop       = issue ? gnt_oh : '0;
   end

   always_comb begin
      rr_d       = rr_q;
      mem_busy_d = mem_busy_q;
      ex_valid_d = ex_valid_q;
      ex_uop_d   = ex_uop_q;
      ex_rs_id_d = ex_rs_id_q;
      ex_t16_d   = ex_t16_q;
      ex_last_d  = ex_last_q;
      if (!hold)
         ex_valid_d = issue;
      if (issue) begin
         ex_uop_d   = gnt_uop;
         ex_rs_id_d = gnt_idx;
         ex_t16_d   = gnt_temp;
         ex_last_d  = gnt_last;
         rr_d       = (gnt_idx == LAST_RS) ? '0 : gnt_idx + TAG_W'(1);
      end
      if (issue && gnt_uop[MEM_BIT])
         mem_busy_d = 1'b1;
      else if (mem_data_wr)
         mem_busy_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (a_rst) begin
         rr_q       <= '0;
         mem_busy_q <= 1'b0;
         ex_valid_q <= 1'b0;
         ex_uop_q   <= '0;
         ex_rs_id_q <= '0;
         ex_t16_q   <= '0;
         ex_last_q  <= 1'b0;
      end else begin
         rr_q       <= rr_d;
         mem_busy_q <= mem_busy_d;
         ex_valid_q <= ex_valid_d;
         ex_uop_q   <= ex_uop_d;
         ex_rs_id_q <= ex_rs_id_d;
         ex_t16_q   <= ex_t16_d;
         ex_last_q  <= ex_last_d;
      end
   end

   assign mem_busy = mem_busy_q;
   assign ex_valid = ex_valid_q;
   assign ex_uop   = ex_uop_q;
   assign ex_rs_id = ex_rs_id_q;
   assign ex_t16   = ex_t16_q;
   assign ex_last  = ex_last_q;
endmodule
